// File: rtl/pulse_stretch.sv
// pulse_stretch -- turns a one-cycle request into an active-low "button press"
// of programmable length, followed by a forced high (release) gap so a
// downstream falling-edge detector always re-arms between presses.
//
// Optional feature: define PULSE_QUEUE_EN to hold one pending request that
// arrives while busy; it is served back-to-back after the release gap.
//
// Ports
//   iCLK   clock, all state on rising edge
//   iRST   synchronous active-high reset
//   iP     request pulse (sampled every edge)
//   iLEN   hold length in cycles (0 treated as 1), sampled on acceptance
//   oY     active-low output level, low while holding
//   oBUSY  high while in HOLD or RELEASE
//   oDROP  one-cycle pulse when a request is discarded
module pulse_stretch #(
  parameter int W   = 8,
  parameter int GAP = 2
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iP,
  input  logic [W-1:0] iLEN,
  output logic         oY,
  output logic         oBUSY,
  output logic         oDROP
);

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;

  // Counter holds "cycles remaining minus one" in the current state.
  localparam logic [W-1:0] GAP_M1 = W'(GAP - 1);

  state_t       state_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] len_d;     // max(iLEN,1)-1, the counter load for a new hold
  logic         busy_req;  // request that cannot start a hold this edge

  assign len_d = (iLEN == '0) ? '0 : iLEN - W'(1);

  // The final RELEASE cycle counts as idle for acceptance, so back-to-back
  // presses lose no extra cycle.
  assign busy_req = iP && ((state_q == HOLD) ||
                           ((state_q == RELEASE) && (cnt_q != '0)));

`ifdef PULSE_QUEUE_EN
  logic         pend_q;
  logic [W-1:0] pend_len_q;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      oY      <= 1'b1;
      oBUSY   <= 1'b0;
      oDROP   <= 1'b0;
`ifdef PULSE_QUEUE_EN
      pend_q     <= 1'b0;
      pend_len_q <= '0;
`endif
    end else begin
      oDROP <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iP) begin
            state_q <= HOLD;
            cnt_q   <= len_d;
            oY      <= 1'b0;
            oBUSY   <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= RELEASE;
            cnt_q   <= GAP_M1;
            oY      <= 1'b1;
          end else begin
            cnt_q <= cnt_q - W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
          end
`ifdef PULSE_QUEUE_EN
          // Pending request wins; a request arriving on this same edge
          // takes over the slot it frees.
          else if (pend_q) begin
            state_q <= HOLD;
            cnt_q   <= pend_len_q;
            oY      <= 1'b0;
            pend_q  <= iP;
            if (iP) pend_len_q <= len_d;
          end
`endif
          else if (iP) begin
            state_q <= HOLD;
            cnt_q   <= len_d;
            oY      <= 1'b0;
          end else begin
            state_q <= IDLE;
            oBUSY   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          oY      <= 1'b1;
          oBUSY   <= 1'b0;
        end
      endcase

`ifdef PULSE_QUEUE_EN
      if (busy_req) begin
        if (!pend_q) begin
          pend_q     <= 1'b1;
          pend_len_q <= len_d;
        end else begin
          oDROP <= 1'b1;
        end
      end
`else
      if (busy_req) oDROP <= 1'b1;
`endif
    end
  end

endmodule
